// File: rtl/mult_operand_gate_ctrl.sv
// mult_operand_gate_ctrl: 2-entry operand FIFO feeding a clock-gated multiplier, suppressing repeated pairs
module mult_operand_gate_ctrl #(
  parameter int W     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             mul_en,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  output logic             res_valid,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_issue_cnt,
  output logic [CNT_W-1:0] stat_redund_cnt,
  output logic [CNT_W-1:0] stat_idle_cnt
);
  logic [W-1:0]     fa_q [2];
  logic [W-1:0]     fb_q [2];
  logic             wr_q, rd_q, wr_d, rd_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             en_q, en_d, last_q, last_d, pv_q, rv_q;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] issue_q, issue_d, redund_q, redund_d, idle_q, idle_d;
  logic             push, pop, redund, issue;
  logic [W-1:0]     h_a, h_b;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc, input logic clr);
    return clr ? '0 : (inc && !(&c)) ? c + CNT_W'(1) : c;
  endfunction

  assign in_ready        = cnt_q < 2'd2;
  assign mul_en          = en_q;
  assign mul_a           = a_q;
  assign mul_b           = b_q;
  assign res_valid       = rv_q;
  assign stat_issue_cnt  = issue_q;
  assign stat_redund_cnt = redund_q;
  assign stat_idle_cnt   = idle_q;

  // Head-of-FIFO issue decision; mul_a/mul_b double as the last captured pair
  always_comb begin
    push     = in_valid && in_ready;
    pop      = cnt_q != 2'd0;
    h_a      = fa_q[rd_q];
    h_b      = fb_q[rd_q];
    redund   = pop && last_q && h_a == a_q && h_b == b_q;
    issue    = pop && !redund;
    wr_d     = push ? !wr_q : wr_q;
    rd_d     = pop ? !rd_q : rd_q;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    en_d     = issue;
    a_d      = issue ? h_a : a_q;
    b_d      = issue ? h_b : b_q;
    last_d   = last_q | issue;
    issue_d  = bump(issue_q, issue, stat_clr);
    redund_d = bump(redund_q, redund, stat_clr);
    idle_d   = bump(idle_q, !pop, stat_clr);
  end

  // FIFO storage needs no reset: entries are only read once count says they are valid
  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wr_q] <= in_a;
      fb_q[wr_q] <= in_b;
    end
  end

  // Control state, issue registers, res_valid pipeline and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
      en_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      last_q   <= 1'b0;
      pv_q     <= 1'b0;
      rv_q     <= 1'b0;
      issue_q  <= '0;
      redund_q <= '0;
      idle_q   <= '0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      a_q      <= a_d;
      b_q      <= b_d;
      last_q   <= last_d;
      pv_q     <= pop;
      rv_q     <= pv_q;
      issue_q  <= issue_d;
      redund_q <= redund_d;
      idle_q   <= idle_d;
    end
  end
endmodule
